// File: rtl/ram_pkg.sv
// Shared defaults and helpers for the single-port RAM front end.
package ram_pkg;

    localparam int RAM_DEPTH = 512;
    localparam int RAM_AW    = 9;
    localparam int RAM_DW    = 64;

    // One request byte-enable becomes eight active-low macro bit-write enables.
    function automatic logic [7:0] expand_byte_bweb(input logic byte_en);
        return {8{~byte_en}};
    endfunction

endpackage

// File: rtl/ram_rsp_fifo.sv
// Two-entry response skid FIFO holding read data the consumer has not taken.
module ram_rsp_fifo
    import ram_pkg::*;
#(
    parameter int DW = RAM_DW
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wptr;
    logic          rptr;

    // Pointer and occupancy tracking; a push and pop together leave count unchanged.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) wptr <= ~wptr;
            if (pop)  rptr <= ~rptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    // Data storage needs no reset: count gates whether it is ever looked at.
    always_ff @(posedge clock) begin
        if (push) mem[wptr] <= push_data;
    end

    assign head = mem[rptr];

    // Overflow and underflow are design errors, never legal traffic.
    always_ff @(posedge clock) begin
        if (reset_n) begin
            assert (!(push && !pop && count == 2'd2));
            assert (!(pop && count == 2'd0));
        end
    end

endmodule

// File: rtl/ram_port_ctrl.sv
// Valid/ready front end for a single-port SRAM macro with 1-cycle read latency.
// Read data is bypassed straight from the macro when nothing is queued; when the
// consumer stalls it lands in a 2-entry FIFO. Admission is limited so that the
// FIFO plus the read in flight never exceed two entries.
module ram_port_ctrl
    import ram_pkg::*;
#(
    parameter int DEPTH = RAM_DEPTH,
    parameter int AW    = RAM_AW,
    parameter int DW    = RAM_DW
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wen,
    input  logic [AW-1:0]   req_addr,
    input  logic [DW-1:0]   req_wdata,
    input  logic [DW/8-1:0] req_wmask,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_rdata,
    output logic            ram_ceb,
    output logic            ram_web,
    output logic [DW-1:0]   ram_bweb,
    output logic [AW-1:0]   ram_a,
    output logic [DW-1:0]   ram_d,
    input  logic [DW-1:0]   ram_q
);

    logic          fire;
    logic          wr_fire;
    logic          rd_fire;
    logic          inflight;
    logic          push;
    logic          pop;
    logic [1:0]    rsp_count;
    logic [DW-1:0] fifo_head;
    logic [DW-1:0] bweb_wr;

    // Accept only while queued + in-flight responses leave room; reset blocks all traffic.
    assign req_ready = reset_n & ((rsp_count == 2'd0) | ((rsp_count == 2'd1) & ~inflight));
    assign fire      = req_valid & req_ready;
    assign wr_fire   = fire & req_wen;
    assign rd_fire   = fire & ~req_wen;

    assign ram_ceb = ~fire;
    assign ram_web = ~wr_fire;
    assign ram_a   = req_addr;
    assign ram_d   = req_wdata;

    for (genvar b = 0; b < DW/8; b++) begin : g_bweb
        assign bweb_wr[b*8 +: 8] = expand_byte_bweb(req_wmask[b]);
    end

    assign ram_bweb = wr_fire ? bweb_wr : '1;

    // A read issued this cycle has its data on ram_q next cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) inflight <= 1'b0;
        else          inflight <= rd_fire;
    end

    // Queued data is older than the in-flight read, so it is presented first.
    assign rsp_valid = reset_n & ((rsp_count != 2'd0) | inflight);
    assign rsp_rdata = (rsp_count != 2'd0) ? fifo_head : ram_q;

    // Macro data must be captured unless it is consumed directly via the bypass.
    assign push = inflight & ~((rsp_count == 2'd0) & rsp_ready);
    assign pop  = rsp_valid & rsp_ready & (rsp_count != 2'd0);

    ram_rsp_fifo #(.DW(DW)) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (ram_q),
        .pop       (pop),
        .head      (fifo_head),
        .count     (rsp_count)
    );

    // Addresses beyond the macro word count are a caller error.
    always_ff @(posedge clock) begin
        if (reset_n && fire) begin
            assert ({{(32-AW){1'b0}}, req_addr} < DEPTH);
        end
    end

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed and randomized checks of ram_port_ctrl against a behavioral macro.
module tb_ram_port_ctrl;

    localparam int AW = 9;
    localparam int DW = 64;

    logic            clock;
    logic            reset_n;
    logic            req_valid;
    logic            req_ready;
    logic            req_wen;
    logic [AW-1:0]   req_addr;
    logic [DW-1:0]   req_wdata;
    logic [DW/8-1:0] req_wmask;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_ceb;
    logic            ram_web;
    logic [DW-1:0]   ram_bweb;
    logic [AW-1:0]   ram_a;
    logic [DW-1:0]   ram_d;
    logic [DW-1:0]   ram_q;

    int n_chk  = 0;
    int n_pass = 0;

    logic [63:0] mem [512];
    logic [63:0] sb  [16];
    logic [63:0] exp_q [$];

    ram_port_ctrl #(.DEPTH(512), .AW(AW), .DW(DW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wmask (req_wmask),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .ram_ceb   (ram_ceb),
        .ram_web   (ram_web),
        .ram_bweb  (ram_bweb),
        .ram_a     (ram_a),
        .ram_d     (ram_d),
        .ram_q     (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Behavioral macro: bit-masked write, 1-cycle read, garbage on ram_q otherwise.
    always @(posedge clock) begin
        if (!ram_ceb && !ram_web) begin
            mem[ram_a] <= (mem[ram_a] & ram_bweb) | (ram_d & ~ram_bweb);
            ram_q      <= {$urandom, $urandom};
        end else if (!ram_ceb) begin
            ram_q      <= mem[ram_a];
        end else begin
            ram_q      <= {$urandom, $urandom};
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drv(input logic v, input logic w, input int a, input logic [63:0] d,
                       input logic [7:0] m);
        req_valid = v;
        req_wen   = w;
        req_addr  = AW'(a);
        req_wdata = d;
        req_wmask = m;
    endtask

    function automatic logic [63:0] pat(input int i);
        return 64'hC0DE_0000_0000_0000 | 64'(i);
    endfunction

    // Scoreboard update/check for one observed cycle of random traffic.
    task automatic observe;
        if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) chk("stress_spurious_rsp", 64'(rsp_valid), 64'd0);
            else                   chk("stress_rsp", rsp_rdata, exp_q.pop_front());
        end
        if (req_valid && req_ready) begin
            if (req_wen) begin
                for (int b = 0; b < 8; b++)
                    if (req_wmask[b]) sb[req_addr[3:0]][b*8 +: 8] = req_wdata[b*8 +: 8];
            end else begin
                exp_q.push_back(sb[req_addr[3:0]]);
            end
        end
    endtask

    localparam logic [63:0] V1 = 64'h0101_0101_1111_0001;
    localparam logic [63:0] V2 = 64'h0202_0202_2222_0002;
    localparam logic [63:0] V3 = 64'h0303_0303_3333_0003;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 64'd0;
        ram_q     = 64'd0;
        reset_n   = 1'b0;
        rsp_ready = 1'b0;
        drv(1'b1, 1'b1, 5, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);

        // Reset: outputs forced even with a write request presented.
        @(negedge clock);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_ram_ceb",   64'(ram_ceb),   64'd1);
        chk("rst_ram_web",   64'(ram_web),   64'd1);
        chk("rst_ram_bweb",  ram_bweb,       64'hFFFF_FFFF_FFFF_FFFF);
        step;
        reset_n = 1'b1;
        drv(1'b0, 1'b0, 0, 64'd0, 8'h00);
        @(negedge clock);
        chk("rel_req_ready", 64'(req_ready), 64'd1);

        // Full write then read back with 1-cycle latency.
        step; drv(1'b1, 1'b1, 5, 64'h1122_3344_5566_7788, 8'hFF);
        @(negedge clock);
        chk("w1_ceb",  64'(ram_ceb), 64'd0);
        chk("w1_web",  64'(ram_web), 64'd0);
        chk("w1_bweb", ram_bweb, 64'd0);
        chk("w1_a",    64'(ram_a), 64'd5);
        chk("w1_d",    ram_d, 64'h1122_3344_5566_7788);
        step; drv(1'b1, 1'b0, 5, 64'd0, 8'h00); rsp_ready = 1'b1;
        @(negedge clock);
        chk("r1_web", 64'(ram_web), 64'd1);
        chk("r1_ceb", 64'(ram_ceb), 64'd0);
        step; drv(1'b0, 1'b0, 0, 64'd0, 8'h00);
        @(negedge clock);
        chk("r1_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("r1_rdata", rsp_rdata, 64'h1122_3344_5566_7788);
        step;
        @(negedge clock);
        chk("r1_rsp_done", 64'(rsp_valid), 64'd0);

        // Partial write; read back, then a write to the same word while data returns.
        step; drv(1'b1, 1'b1, 5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
        @(negedge clock);
        chk("w2_bweb", ram_bweb, 64'hFFFF_FFFF_0000_0000);
        step; drv(1'b1, 1'b0, 5, 64'd0, 8'h00);
        step; drv(1'b1, 1'b1, 5, 64'h5555_5555_5555_5555, 8'hFF);
        @(negedge clock);
        chk("r2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("r2_rdata",     rsp_rdata, 64'h1122_3344_AAAA_AAAA);
        chk("w3_req_ready", 64'(req_ready), 64'd1);
        chk("w3_web",       64'(ram_web), 64'd0);
        step; drv(1'b1, 1'b0, 5, 64'd0, 8'h00);
        step; drv(1'b0, 1'b0, 0, 64'd0, 8'h00);
        @(negedge clock);
        chk("r3_rdata", rsp_rdata, 64'h5555_5555_5555_5555);

        // Backpressure: two reads admitted, third held until a FIFO slot frees.
        step; drv(1'b1, 1'b1, 1, V1, 8'hFF);
        step; drv(1'b1, 1'b1, 2, V2, 8'hFF);
        step; drv(1'b1, 1'b1, 3, V3, 8'hFF);
        step; drv(1'b1, 1'b0, 1, 64'd0, 8'h00); rsp_ready = 1'b0;
        @(negedge clock);
        chk("bp_rd1_ready", 64'(req_ready), 64'd1);
        step; drv(1'b1, 1'b0, 2, 64'd0, 8'h00);
        @(negedge clock);
        chk("bp_rd2_ready", 64'(req_ready), 64'd1);
        chk("bp_bypass_v1", rsp_rdata, V1);
        step; drv(1'b1, 1'b0, 3, 64'd0, 8'h00);
        @(negedge clock);
        chk("bp_rd3_block0", 64'(req_ready), 64'd0);
        chk("bp_count1", 64'(dut.rsp_count), 64'd1);
        step;
        @(negedge clock);
        chk("bp_rd3_block1", 64'(req_ready), 64'd0);
        chk("bp_count2", 64'(dut.rsp_count), 64'd2);
        chk("bp_head_v1", rsp_rdata, V1);
        step; rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_no_popthru", 64'(req_ready), 64'd0);
        chk("bp_out_v1", rsp_rdata, V1);
        step;
        @(negedge clock);
        chk("bp_rd3_accept", 64'(req_ready), 64'd1);
        chk("bp_out_v2", rsp_rdata, V2);
        step; drv(1'b0, 1'b0, 0, 64'd0, 8'h00);
        @(negedge clock);
        chk("bp_v3_valid", 64'(rsp_valid), 64'd1);
        chk("bp_out_v3", rsp_rdata, V3);
        step;
        @(negedge clock);
        chk("bp_empty", 64'(rsp_valid), 64'd0);

        // Streaming: 16 back-to-back reads, one response per cycle, FIFO unused.
        for (int i = 0; i < 16; i++) begin
            step; drv(1'b1, 1'b1, i, pat(i), 8'hFF);
        end
        for (int i = 0; i < 16; i++) begin
            step; drv(1'b1, 1'b0, i, 64'd0, 8'h00);
            @(negedge clock);
            chk("st_ready", 64'(req_ready), 64'd1);
            chk("st_count", 64'(dut.rsp_count), 64'd0);
            if (i > 0) chk("st_rdata", rsp_rdata, pat(i - 1));
        end
        step; drv(1'b0, 1'b0, 0, 64'd0, 8'h00);
        @(negedge clock);
        chk("st_last_valid", 64'(rsp_valid), 64'd1);
        chk("st_last_rdata", rsp_rdata, pat(15));

        // Reset while a read is in flight drops it.
        step; drv(1'b1, 1'b0, 3, 64'd0, 8'h00);
        step; reset_n = 1'b0;
        @(negedge clock);
        chk("mr_ceb",       64'(ram_ceb),   64'd1);
        chk("mr_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("mr_req_ready", 64'(req_ready), 64'd0);
        step; reset_n = 1'b1; drv(1'b0, 1'b0, 0, 64'd0, 8'h00);
        @(negedge clock);
        chk("mr_rel_ready", 64'(req_ready), 64'd1);
        chk("mr_rel_valid", 64'(rsp_valid), 64'd0);
        step;
        @(negedge clock);
        chk("mr_rel_valid2", 64'(rsp_valid), 64'd0);

        // Random traffic over addresses 0..15 against the scoreboard.
        for (int i = 0; i < 16; i++) sb[i] = pat(i);
        for (int c = 0; c < 400; c++) begin
            step;
            drv(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                {$urandom, $urandom}, 8'($urandom_range(0, 255)));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            observe();
        end
        step; drv(1'b0, 1'b0, 0, 64'd0, 8'h00); rsp_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            observe();
            step;
        end
        @(negedge clock);
        chk("stress_drained", 64'(exp_q.size()), 64'd0);
        chk("stress_idle",    64'(rsp_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
